// File: rtl/cache_mem_arbiter_pkg.sv
// ============================================================================
// Module : cache_mem_arbiter_pkg
// Brief  : Shared types and constants for the I/D cache memory-port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_mem_arbiter_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_I    = 2'd1;
  localparam arb_state_t ARB_D    = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// Module : cache_mem_arbiter
// Brief  : Grants the shared line-wide memory port to the I- or D-cache,
//          D-priority with I starvation bound and writeback/allocate locking.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_dfp_addr,
  input  logic              i_dfp_read,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic              i_dfp_resp,
  input  logic [ADDR_W-1:0] d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arb_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;

  logic i_req, d_req, go_i, go_d;

  assign i_req = i_dfp_read;
  assign d_req = d_dfp_read | d_dfp_write;

  // Locked allocate wins outright; otherwise D has priority unless I is starved.
  always_comb begin
    go_i = 1'b0;
    go_d = 1'b0;
    if (lock_q && d_dfp_read)                      go_d = 1'b1;
    else if (i_req && (!d_req || starve_q >= LIMIT)) go_i = 1'b1;
    else if (d_req)                                go_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lock_d   = lock_q;
    err_d    = err_q;
    if (d_dfp_read && d_dfp_write) err_d = 1'b1;
    case (state_q)
      ARB_IDLE: begin
        if (mem_resp) err_d = 1'b1;
        if (!i_req)   starve_d = '0;
        if (go_i) begin
          state_d  = ARB_I;
          starve_d = '0;
          lock_d   = 1'b0;
        end else if (go_d) begin
          state_d = ARB_D;
          lock_d  = 1'b0;
          if (i_req) starve_d = sat_inc(starve_q);
        end
      end
      ARB_I: begin
        if (mem_resp) state_d = ARB_IDLE;
      end
      ARB_D: begin
        if (mem_resp) begin
          state_d = ARB_IDLE;
          if (d_dfp_write) lock_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  // A simultaneous D read+write is serviced as the write.
  always_comb begin
    mem_addr   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    i_dfp_resp = 1'b0;
    d_dfp_resp = 1'b0;
    case (state_q)
      ARB_I: begin
        mem_addr   = i_dfp_addr;
        mem_read   = i_dfp_read;
        i_dfp_resp = mem_resp;
      end
      ARB_D: begin
        mem_addr   = d_dfp_addr;
        mem_write  = d_dfp_write;
        mem_read   = d_dfp_read & ~d_dfp_write;
        mem_wdata  = d_dfp_wdata;
        d_dfp_resp = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_dfp_rdata = mem_rdata;
  assign d_dfp_rdata = mem_rdata;
  assign arb_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// Module : tb_cache_mem_arbiter
// Brief  : Self-checking bench for cache_mem_arbiter with a grant-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int MLAT  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_dfp_addr;
  logic         i_dfp_read;
  logic [255:0] i_dfp_rdata;
  logic         i_dfp_resp;
  logic [31:0]  d_dfp_addr;
  logic         d_dfp_read;
  logic         d_dfp_write;
  logic [255:0] d_dfp_wdata;
  logic [255:0] d_dfp_rdata;
  logic         d_dfp_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         arb_err;

  cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
    .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  bit    mem_auto = 1'b1;
  string o_log = "";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=\"%s\" want=\"%s\"", name, act, exp);
    end
  endtask

  function automatic string tail(input string s, input int from);
    if (s.len() <= from) return "";
    return s.substr(from, s.len() - 1);
  endfunction

  // Grant-level model: who owns the port, lock, starvation count, sticky error.
  int    m_owner = 0;   // 0 none, 1 I-cache, 2 D-cache
  int    m_starve = 0;
  bit    m_lock = 1'b0;
  bit    m_err = 1'b0;
  string m_log = "";

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner  <= 0;
      m_starve <= 0;
      m_lock   <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      automatic bit    dreq = d_dfp_read || d_dfp_write;
      automatic int    nxt  = m_owner;
      automatic int    st   = m_starve;
      automatic bit    lk   = m_lock;
      automatic bit    er   = m_err;
      automatic string add  = "";
      if (d_dfp_read && d_dfp_write) er = 1'b1;
      if (m_owner == 0) begin
        if (mem_resp) er = 1'b1;
        if (!i_dfp_read) st = 0;
        if (m_lock && d_dfp_read) nxt = 2;
        else if (i_dfp_read && (!dreq || m_starve >= LIMIT)) nxt = 1;
        else if (dreq) nxt = 2;
        if (nxt == 1) begin
          st = 0;
          add = "I";
        end
        if (nxt == 2) begin
          if (i_dfp_read) st = (st < 15) ? st + 1 : 15;
          add = d_dfp_write ? "W" : "R";
        end
        if (nxt != 0) lk = 1'b0;
      end else if (mem_resp) begin
        if (m_owner == 2 && d_dfp_write) lk = 1'b1;
        nxt = 0;
      end
      m_owner  <= nxt;
      m_starve <= st;
      m_lock   <= lk;
      m_err    <= er;
      m_log    <= {m_log, add};
    end
  end

  // Per-cycle output comparison against the model.
  always @(negedge clk) begin
    automatic logic [31:0]  e_addr  = (m_owner == 1) ? i_dfp_addr : (m_owner == 2) ? d_dfp_addr : 32'h0;
    automatic logic         e_rd    = (m_owner == 1) ? i_dfp_read : (m_owner == 2) ? (d_dfp_read && !d_dfp_write) : 1'b0;
    automatic logic         e_wr    = (m_owner == 2) ? d_dfp_write : 1'b0;
    automatic logic [255:0] e_wdata = (m_owner == 2) ? d_dfp_wdata : 256'h0;
    automatic logic         e_ir    = (m_owner == 1) && mem_resp;
    automatic logic         e_dr    = (m_owner == 2) && mem_resp;
    automatic bit wd_ok = (mem_wdata === e_wdata);
    automatic bit rd_ok = (i_dfp_rdata === mem_rdata) && (d_dfp_rdata === mem_rdata);
    total++;
    if (mem_addr !== e_addr || mem_read !== e_rd || mem_write !== e_wr || !wd_ok || !rd_ok ||
        i_dfp_resp !== e_ir || d_dfp_resp !== e_dr || arb_err !== m_err) begin
      bad++;
      $display("FAIL cycle_outputs cyc=%0d got addr=%h rd=%b wr=%b ir=%b dr=%b err=%b wdata_ok=%b rdata_ok=%b want addr=%h rd=%b wr=%b ir=%b dr=%b err=%b",
               cyc, mem_addr, mem_read, mem_write, i_dfp_resp, d_dfp_resp, arb_err, wd_ok, rd_ok,
               e_addr, e_rd, e_wr, e_ir, e_dr, m_err);
    end
    if (i_dfp_resp) o_log <= {o_log, "I"};
    if (d_dfp_resp) o_log <= {o_log, mem_write ? "W" : "R"};
  end

  // Memory model: fixed latency after a request is first seen.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && (mem_read || mem_write)) begin
        automatic logic [31:0] a = mem_addr;
        repeat (MLAT) @(posedge clk);
        #1;
        mem_rdata = (a == 32'h1000) ? {32{8'hA5}} : {8{a ^ 32'h5A5A_0000}};
        mem_resp  = 1'b1;
        @(posedge clk);
        #1 mem_resp = 1'b0;
      end
    end
  end

  task automatic i_req(input logic [31:0] a, output int rc);
    int n = 0;
    i_dfp_addr = a;
    i_dfp_read = 1'b1;
    rc = -1;
    while (n < 80) begin
      @(negedge clk);
      if (i_dfp_resp) begin
        rc = cyc;
        break;
      end
      n++;
    end
    if (rc < 0) begin
      total++; bad++;
      $display("FAIL i_resp_timeout got=none want=resp addr=%h", a);
    end
    @(posedge clk);
    #1 i_dfp_read = 1'b0;
  endtask

  task automatic d_req(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [255:0] wd, output int rc);
    int n = 0;
    d_dfp_addr  = a;
    d_dfp_wdata = wd;
    d_dfp_write = wr;
    d_dfp_read  = rd;
    rc = -1;
    while (n < 80) begin
      @(negedge clk);
      if (d_dfp_resp) begin
        rc = cyc;
        break;
      end
      n++;
    end
    if (rc < 0) begin
      total++; bad++;
      $display("FAIL d_resp_timeout got=none want=resp addr=%h", a);
    end
    @(posedge clk);
    #1;
    d_dfp_read  = 1'b0;
    d_dfp_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int t0, rc_i, rc_d, rc, o0, m0;
    rst = 1'b0;
    i_dfp_addr = '0; i_dfp_read = 1'b0;
    d_dfp_addr = '0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_mem_read",  mem_read,   1'b0);
    chk("rst_mem_write", mem_write,  1'b0);
    chk("rst_mem_addr",  mem_addr,   32'h0);
    chk("rst_i_resp",    i_dfp_resp, 1'b0);
    chk("rst_d_resp",    d_dfp_resp, 1'b0);
    chk("rst_arb_err",   arb_err,    1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    gap();

    // Single I read: grant next cycle, resp MLAT cycles after grant.
    t0 = cyc;
    i_dfp_addr = 32'h0000_1000;
    i_dfp_read = 1'b1;
    @(negedge clk);
    chk("i_read_idle_cycle", mem_read, 1'b0);
    @(negedge clk);
    chk("i_read_latency", mem_read, 1'b1);
    chk("i_read_addr", mem_addr, 32'h0000_1000);
    repeat (MLAT) @(negedge clk);
    chk("i_resp_cycle", i_dfp_resp, 1'b1);
    chk("i_resp_delay", 32'(cyc - t0), 32'd4);
    chk("i_rdata", i_dfp_rdata, {32{8'hA5}});
    chk("i_only_d_resp", d_dfp_resp, 1'b0);
    @(posedge clk);
    #1 i_dfp_read = 1'b0;
    gap();

    // Simultaneous I and D: D first, I granted two cycles after D resp.
    o0 = o_log.len(); m0 = m_log.len();
    fork
      i_req(32'h0000_0100, rc_i);
      d_req(1'b0, 1'b1, 32'h0000_0200, '0, rc_d);
    join
    gap();
    chk_str("both_order_dut", tail(o_log, o0), "RI");
    chk_str("both_order_model", tail(m_log, m0), "RI");
    chk("both_i_after_d", 32'(rc_i - rc_d), 32'(2 + MLAT));

    // Writeback then allocate stay back-to-back while I waits.
    o0 = o_log.len(); m0 = m_log.len();
    fork
      i_req(32'h0000_0500, rc_i);
      begin
        d_req(1'b1, 1'b0, 32'h0000_0300, {8{32'hDEAD_BEEF}}, rc);
        d_req(1'b0, 1'b1, 32'h0000_0400, '0, rc_d);
      end
    join
    gap();
    chk_str("wb_alloc_order_dut", tail(o_log, o0), "WRI");
    chk_str("wb_alloc_order_model", tail(m_log, m0), "WRI");

    // Starvation: I forced after exactly LIMIT D grants.
    o0 = o_log.len(); m0 = m_log.len();
    fork
      i_req(32'h0000_0600, rc_i);
      for (int k = 0; k < 6; k++) d_req(1'b0, 1'b1, 32'h0000_0700 + 32'(k * 32), '0, rc_d);
    join
    gap();
    chk_str("starve_order_dut", tail(o_log, o0), "RRRRIRR");
    chk_str("starve_order_model", tail(m_log, m0), "RRRRIRR");

    // Stray mem_resp in idle.
    mem_auto = 1'b0;
    mem_resp = 1'b1;
    @(negedge clk);
    chk("stray_i_resp", i_dfp_resp, 1'b0);
    chk("stray_d_resp", d_dfp_resp, 1'b0);
    @(posedge clk);
    #1 mem_resp = 1'b0;
    mem_auto = 1'b1;
    @(negedge clk);
    chk("stray_err", arb_err, 1'b1);
    do_reset();
    @(negedge clk);
    chk("err_cleared_by_reset", arb_err, 1'b0);
    @(posedge clk);
    #1;

    // D read and write together: write serviced, error flagged.
    o0 = o_log.len();
    d_req(1'b1, 1'b1, 32'h0000_0800, {8{32'h1234_5678}}, rc_d);
    chk_str("rw_both_serviced", tail(o_log, o0), "W");
    chk("rw_both_err", arb_err, 1'b1);
    do_reset();
    gap();

    // Reset mid-ARB_D: outputs drop asynchronously, late resp flags error.
    d_dfp_addr  = 32'h0000_0900;
    d_dfp_wdata = {8{32'hCAFE_F00D}};
    d_dfp_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_d_write_granted", mem_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_write", mem_write, 1'b0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    d_dfp_write = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("after_rst_idle_write", mem_write, 1'b0);
    repeat (4) @(negedge clk);
    chk("late_resp_err", arb_err, 1'b1);

    // Fresh arbitration after reset: counter cleared so D still wins first.
    do_reset();
    gap();
    o0 = o_log.len();
    fork
      i_req(32'h0000_0A00, rc_i);
      d_req(1'b0, 1'b1, 32'h0000_0B00, '0, rc_d);
    join
    gap();
    chk_str("post_rst_order", tail(o_log, o0), "RI");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
